// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and default widths for the instruction fetch unit.
//   fetch_state_e : fetch control state (RUN, FAULT)
//   fetch_entry_t : {instr, pc} entry held in the fetch buffer (default widths)
//   PC_W_DEF, INSTR_W_DEF, FIFO_DEPTH_DEF : default parameter values
//   cnt_width()   : width of an occupancy counter for a given depth
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W_DEF       = 16;
    localparam int INSTR_W_DEF    = 32;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    pc;
    } fetch_entry_t;

    // An occupancy counter must be able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO, used both as the request tag queue and as the
// fetched-instruction buffer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push, data : write an entry (caller guarantees not full)
//   pop        : drop the head entry (caller guarantees not empty)
//   flush      : empty the FIFO; push/pop in the same cycle are ignored
//   head       : entry at the head (registered storage)
//   count      : current number of entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage between the program counter and decode. Issues in-order
// instruction memory requests under a credit limit, tags each response with
// its PC, buffers {instr, pc} and hands it to decode. flush_i discards all
// wrong-path work; stale in-flight responses are dropped via drop_cnt.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned PCs
// (sticky fetch_fault_o, cleared only by flush_i).
// Ports:
//   clk, rst                              : clock, async active-high reset
//   pc_i, flush_i, pc_advance_o           : program counter interface
//   imem_req_valid_o/ready_i, imem_addr_o : memory request channel
//   imem_rsp_valid_i, imem_rsp_data_i     : memory response channel
//   id_valid_o/ready_i, id_instr_o, id_pc_o : decode channel
//   fetch_fault_o                         : misaligned-PC fault
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = PC_W_DEF,
    parameter int INSTR_WIDTH = INSTR_W_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_i,
    input  logic                   flush_i,
    output logic                   pc_advance_o,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic                   fetch_fault_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = INSTR_WIDTH + PC_WIDTH;

    fetch_state_e        state, state_nxt;
    logic [CW-1:0]       out_cnt;
    logic [CW-1:0]       buf_cnt;
    logic [CW-1:0]       drop_cnt;
    logic [PC_WIDTH-1:0] tag_head;
    logic [EW-1:0]       buf_head;
    logic                base_ok;
    logic                misalign;
    logic                accept;
    logic                rsp_take;
    logic                rsp_keep;
    logic                id_pop;

    // Credits come from registered counts only, so a same-cycle pop or
    // response never frees room for a request in that cycle.
    assign base_ok = !rst && !flush_i && (state == RUN)
                     && ((out_cnt + buf_cnt) < CW'(FIFO_DEPTH));

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = (pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
`ifdef FETCH_MISALIGN_TRAP_EN
        case (state)
            RUN:     if (base_ok && misalign) state_nxt = FAULT;
            FAULT:   if (flush_i)             state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
`else
        state_nxt = RUN;
`endif
    end

    // Output logic
    always_comb begin
        imem_req_valid_o = base_ok && !misalign;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault_o    = (state == FAULT);
`else
        fetch_fault_o    = 1'b0;
`endif
    end

    assign imem_addr_o  = pc_i;
    assign pc_advance_o = imem_req_valid_o && imem_req_ready_i;
    assign accept       = pc_advance_o;

    // Every response retires one tag; it is kept only when no stale responses
    // remain to be dropped and no flush is discarding it this cycle.
    assign rsp_take = imem_rsp_valid_i && (out_cnt != '0);
    assign rsp_keep = rsp_take && (drop_cnt == '0) && !flush_i;
    assign id_pop   = id_valid_o && id_ready_i && !flush_i;

    fetch_fifo #(.WIDTH(PC_WIDTH), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .data  (pc_i),
        .pop   (rsp_take),
        .flush (1'b0),
        .head  (tag_head),
        .count (out_cnt)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_buf_q (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .data  ({imem_rsp_data_i, tag_head}),
        .pop   (id_pop),
        .flush (flush_i),
        .head  (buf_head),
        .count (buf_cnt)
    );

    // On flush every request still in flight is wrong-path; one consumed in
    // the flush cycle itself is already gone, so it is not counted again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (flush_i) begin
            drop_cnt <= out_cnt - CW'(rsp_take);
        end else if (rsp_take && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    assign id_valid_o = (buf_cnt != '0);
    assign id_instr_o = buf_head[EW-1:PC_WIDTH];
    assign id_pc_o    = buf_head[PC_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a simple in-order memory that
// answers one cycle after each accepted request (data = {16'hC0DE, addr}).
// Define FETCH_MISALIGN_TRAP_EN to exercise the misaligned-PC trap.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_i;
    logic        flush_i;
    logic        pc_advance_o;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [15:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [15:0] id_pc_o;
    logic        fetch_fault_o;

    int          total = 0;
    int          bad   = 0;
    logic        rsp_en;
    logic [15:0] flush_tgt;
    logic [15:0] mem_q [$];
    logic [15:0] acc_q [$];
    logic [15:0] got_pc [$];
    logic [31:0] got_ins [$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .flush_i          (flush_i),
        .pc_advance_o     (pc_advance_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o),
        .fetch_fault_o    (fetch_fault_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample handshakes, clock, then update PC and memory.
    task automatic cyc();
        logic        acc;
        logic [15:0] a;
        #1;
        acc = pc_advance_o;
        a   = imem_addr_o;
        if (id_valid_o && id_ready_i && !flush_i) begin
            got_pc.push_back(id_pc_o);
            got_ins.push_back(id_instr_o);
        end
        @(posedge clk);
        if (acc) begin
            mem_q.push_back(a);
            acc_q.push_back(a);
        end
        #1;
        if (flush_i)  pc_i = flush_tgt;
        else if (acc) pc_i = pc_i + 16'd4;
        if (rsp_en && mem_q.size() > 0) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = {16'hC0DE, mem_q[0]};
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
        end
    endtask

    task automatic do_reset(input logic [15:0] pc);
        rst              = 1'b1;
        pc_i             = pc;
        flush_i          = 1'b0;
        flush_tgt        = '0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        id_ready_i       = 1'b1;
        rsp_en           = 1'b1;
        mem_q.delete();
        acc_q.delete();
        got_pc.delete();
        got_ins.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset(16'h0000);
        rst = 1'b1;
        #1;
        chk("rst_id_valid", id_valid_o, 0);
        chk("rst_req_valid", imem_req_valid_o, 0);
        chk("rst_advance", pc_advance_o, 0);
        chk("rst_fault", fetch_fault_o, 0);
        chk("rst_drop", dut.drop_cnt, 0);
        rst = 1'b0;

        // 1: streaming fetch with memory and decode always ready
        do_reset(16'h0000);
        #1;
        chk("t1_addr_passthru", imem_addr_o, 16'h0000);
        cyc();                                  // accept 0
        cyc();                                  // accept 4, rsp 0
        chk("t1_out_c1", dut.out_cnt, 1);
        chk("t1_buf_c1", dut.buf_cnt, 1);
        cyc();                                  // rsp 4 + pop 0
        chk("t1_out_c2", dut.out_cnt, 0);
        chk("t1_buf_rsp_pop", dut.buf_cnt, 1);
        cyc();                                  // accept 8, pop 4
        cyc();                                  // accept 12 + rsp 8
        chk("t1_out_acc_rsp", dut.out_cnt, 1);
        chk("t1_buf_c4", dut.buf_cnt, 1);
        cyc();
        cyc();
        chk("t1_accepts", acc_q.size(), 5);
        chk("t1_npop", got_pc.size() >= 3, 1);
        chk("t1_pc0", got_pc[0], 16'h0000);
        chk("t1_pc1", got_pc[1], 16'h0004);
        chk("t1_pc2", got_pc[2], 16'h0008);
        chk("t1_ins1", got_ins[1], 32'hC0DE0004);

        // 2: decode stalled for 6 cycles
        do_reset(16'h0000);
        id_ready_i = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_hold_pc", id_pc_o, 16'h0000);
            chk("t2_hold_ins", id_instr_o, 32'hC0DE0000);
        end
        chk("t2_accepts", acc_q.size(), 2);
        chk("t2_req_off", imem_req_valid_o, 0);
        chk("t2_id_valid", id_valid_o, 1);
        chk("t2_pc_next", pc_i, 16'h0008);
        id_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("t2_resume_addr", acc_q[2], 16'h0008);
        chk("t2_pc2", got_pc[2], 16'h0008);

        // 3: flush with two requests outstanding
        do_reset(16'h0010);
        rsp_en = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("t3_accepts", acc_q.size(), 2);
        chk("t3_outstanding", dut.out_cnt, 2);
        flush_i   = 1'b1;
        flush_tgt = 16'h0040;
        #1;
        chk("t3_flush_noreq", imem_req_valid_o, 0);
        cyc();
        flush_i = 1'b0;
        chk("t3_drop_set", dut.drop_cnt, 2);
        chk("t3_pc_tgt", pc_i, 16'h0040);
        rsp_en = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("t3_first_pc", got_pc[0], 16'h0040);
        chk("t3_first_ins", got_ins[0], 32'hC0DE0040);
        chk("t3_drop_zero", dut.drop_cnt, 0);
        chk("t3_req_after", acc_q[2], 16'h0040);

        // 5: asynchronous reset with the buffer full
        do_reset(16'h0000);
        id_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("t5_full", dut.buf_cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_id_valid", id_valid_o, 0);
        chk("t5_req_valid", imem_req_valid_o, 0);
        chk("t5_advance", pc_advance_o, 0);
        chk("t5_buf_empty", dut.buf_cnt, 0);
        @(posedge clk);
        #1;
        pc_i             = 16'h0080;
        id_ready_i       = 1'b1;
        imem_rsp_valid_i = 1'b0;
        mem_q.delete();
        acc_q.delete();
        rst = 1'b0;
        cyc();
        chk("t5_first_req", acc_q[0], 16'h0080);

`ifdef FETCH_MISALIGN_TRAP_EN
        // 6: misaligned PC traps until flush
        do_reset(16'h0022);
        #1;
        chk("t6_noreq", imem_req_valid_o, 0);
        cyc();
        chk("t6_fault", fetch_fault_o, 1);
        cyc();
        chk("t6_sticky", fetch_fault_o, 1);
        chk("t6_accepts", acc_q.size(), 0);
        flush_i   = 1'b1;
        flush_tgt = 16'h0024;
        cyc();
        flush_i = 1'b0;
        chk("t6_cleared", fetch_fault_o, 0);
        cyc();
        chk("t6_resume", acc_q[0], 16'h0024);
`else
        // Without the trap, a misaligned PC is fetched unchanged
        do_reset(16'h0022);
        cyc();
        chk("nt_addr", acc_q[0], 16'h0022);
        chk("nt_fault", fetch_fault_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
